instr_controller: RTL and testbench
===================================

# instr_controller

Instruction register, decoder and control FSM that sits directly upstream of the datapath and drives every one of its control inputs. It latches one 16-bit instruction and extracts the register numbers, immediates, shift and ALU op. After a start pulse it sequences the datapath through register reads, ALU execution and register write-back, one control step per cycle. It reports completion on a wait/ready flag.

## Interface
Parameters: none; all widths are fixed by the datapath.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in  in  16  instruction word
- load  in  1  instruction-register load enable; honoured only in WAIT
- s  in  1  start execution of the latched instruction; honoured only in WAIT
- w  out  1  1 = idle in WAIT and ready for load/s
- sximm8  out  16  sign-extended IR[7:0]
- sximm5  out  16  sign-extended IR[4:0]
- shift  out  2  IR[4:3]
- ALUop  out  2  ALU operation (see Operation)
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write strobe
- loada, loadb, loadc, loads  out  1 each  datapath register load strobes
- asel, bsel  out  1 each  datapath operand selects; asel=1 forces the A operand to 0, bsel=1 selects sximm5
- vsel  out  4  one-hot write-back select: [3]=mdata, [2]=sximm8, [1]=PC, [0]=datapath_out

## Operation
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,sh(Rm)
  - 101/00 ADD Rd=Rn+sh(Rm)
  - 101/01 CMP, status only, Rn−sh(Rm)
  - 101/10 AND Rd=Rn&sh(Rm)
  - 101/11 MVN Rd=~sh(Rm)
- Any other opcode/op is illegal: DECODE returns to WAIT with no strobes.
- ALUop = op for opcode 101; ALUop = 00 for opcode 110.
- Moore FSM; all outputs are decoded from state and IR only. Unlisted strobes are 0. vsel=0001, asel=0, bsel=0 unless stated.
- readnum = Rn in GET_A, otherwise Rm.
- writenum = Rd in WRITE_RD, otherwise Rn.
- States and transitions:
  - WAIT: w=1. s=1 → DECODE.
  - DECODE:
    - MOV imm → WRITE_IMM
    - MOV reg, MVN → GET_B
    - ADD, CMP, AND → GET_A
    - illegal → WAIT
  - GET_A: loada=1 → GET_B.
  - GET_B: loadb=1 → EXEC.
  - EXEC:
    - asel=1 for MOV reg and MVN.
    - CMP: loads=1 → WAIT.
    - Others: loadc=1 → WRITE_RD.
  - WRITE_RD: write=1, vsel=0001 → WAIT.
  - WRITE_IMM: write=1, vsel=0100 → WAIT.
- IR loads `in` on any edge with load=1 while in WAIT. load outside WAIT is ignored and IR holds.

## Timing
- Reset: on any edge with reset_n=0, state=WAIT, IR=0, regardless of current state; this aborts mid-instruction with no further strobes.
- Outputs after reset: w=1; all strobes 0; vsel=0001; sximm8=sximm5=0; shift=00; ALUop=00; readnum=writenum=0.
- s is sampled at edge E0. w falls in the cycle after E0 and rises again after the busy period:
  - MOV imm: busy 2 cycles
  - MOV reg, MVN, CMP: busy 4 cycles
  - ADD, AND: busy 5 cycles
  - illegal: busy 1 cycle
- The register-file write completes at the edge on which w rises.
- load and s together in WAIT: IR takes the new word at the same edge, and DECODE uses the new word.
- s held high continuously: a new instruction starts on the first cycle back in WAIT (w=1 for exactly one cycle).
- Strobes are single-cycle, one state per cycle. No strobe is asserted in WAIT.

## Test plan
- Reset: hold reset_n=0 for 2 edges mid-ADD (in GET_B) → next cycle w=1, IR=0, loadb=0, no write strobe ever follows.
- MOV imm: load in=16'hD2FE (MOV R2,#−2), pulse s → WRITE_IMM shows writenum=2, vsel=0100, sximm8=16'hFFFE, write=1; w low exactly 2 cycles.
- ADD: in=16'hA1A8 (ADD R5,R1,R0 LSL#1) → sequence GET_A(readnum=1, loada), GET_B(readnum=0, loadb, shift=01), EXEC(ALUop=00, loadc), WRITE_RD(writenum=5, write); w low 5 cycles.
- CMP/MVN: in=16'hAB01 (CMP R3,R1) → loads=1 in EXEC, never write/loadc, 4 cycles. in=16'hB8E2 (MVN R7,R2) → asel=1, ALUop=11 in EXEC, then write to R7.
- Handshake: load=1 with a new word while busy → IR unchanged. load+s together in WAIT → new word executes. Illegal opcode 000 → WAIT after 1 cycle, no strobes.

Source files
------------

// File: rtl/instr_controller.sv
// instr_controller: instruction register, decoder and control sequencer for the datapath.
// Latches one 16-bit instruction in WAIT, then walks the datapath through operand
// reads, ALU execution and register write-back, one control step per cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   synchronous active-low reset
//   in        in   16-bit instruction word
//   load      in   IR load enable (honoured only in WAIT)
//   s         in   start execution (honoured only in WAIT)
//   w         out  idle in WAIT, ready for load/s
//   sximm8    out  sign-extended IR[7:0]
//   sximm5    out  sign-extended IR[4:0]
//   shift     out  IR[4:3]
//   ALUop     out  ALU operation
//   readnum   out  register-file read index
//   writenum  out  register-file write index
//   write     out  register-file write strobe
//   loada/b/c/s out datapath register load strobes
//   asel,bsel out  operand selects (asel=1 zeroes A, bsel=1 picks sximm5)
//   vsel      out  one-hot write-back select {mdata, sximm8, PC, datapath_out}
module instr_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [3:0]  vsel
);

  localparam int unsigned IR_W = 16;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_RD  = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;

  // IR field extraction
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign rm     = ir_q[2:0];

  // Instruction classification
  logic is_alu, is_mov, mov_imm, mov_reg, is_mvn, is_cmp, needs_a;

  assign is_alu  = (opcode == 3'b101);
  assign is_mov  = (opcode == 3'b110);
  assign mov_imm = is_mov && (op == 2'b10);
  assign mov_reg = is_mov && (op == 2'b00);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);
  // ADD, CMP and AND read Rn into A; MOV reg and MVN skip straight to B
  assign needs_a = is_alu && (op != 2'b11);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register: loads only while idle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_q <= '0;
    end else begin
      ir_q <= ir_d;
    end
  end

  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && load) begin
      ir_d = in;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT: begin
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (mov_imm)                state_d = S_WRITE_IMM;
        else if (mov_reg || is_mvn) state_d = S_GET_B;
        else if (needs_a)           state_d = S_GET_A;
        else                        state_d = S_WAIT;
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_RD;
      S_WRITE_RD:  state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // Moore outputs decoded from state and IR
  always_comb begin
    w        = 1'b0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 4'b0001;
    readnum  = rm;
    writenum = rn;
    sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
    sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
    shift    = ir_q[4:3];
    ALUop    = is_alu ? op : 2'b00;
    unique case (state_q)
      S_WAIT: w = 1'b1;
      S_DECODE: ;
      S_GET_A: begin
        loada   = 1'b1;
        readnum = rn;
      end
      S_GET_B: loadb = 1'b1;
      S_EXEC: begin
        asel = mov_reg || is_mvn;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      S_WRITE_RD: begin
        write    = 1'b1;
        writenum = rd;
      end
      S_WRITE_IMM: begin
        write = 1'b1;
        vsel  = 4'b0100;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// Testbench for instr_controller: per-cycle scoreboard against an instruction-level model.
module tb_instr_controller;

  typedef struct packed {
    logic        w;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [3:0]  vsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [1:0]  shift;
    logic [1:0]  aluop;
  } outv_t;

  localparam int P_DEC = 0;
  localparam int P_GA  = 1;
  localparam int P_GB  = 2;
  localparam int P_EX  = 3;
  localparam int P_WR  = 4;
  localparam int P_WI  = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] sximm8, sximm5;
  logic [1:0]  shift, ALUop;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;

  instr_controller dut (
    .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s),
    .w(w), .sximm8(sximm8), .sximm5(sximm5), .shift(shift), .ALUop(ALUop),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel)
  );

  always #5 clk = ~clk;

  outv_t act;
  assign act = {w, write, loada, loadb, loadc, loads, asel, bsel, vsel,
                readnum, writenum, sximm8, sximm5, shift, ALUop};

  // Scoreboard and model state
  outv_t       exp_q[$];
  int          cyc_q[$];
  outv_t       busy_q[$];
  logic [15:0] ir_m = '0;
  bit          idle_m = 1'b1;
  int          cyc_n = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic outv_t rec_base(input logic [15:0] ir);
    outv_t r;
    r          = '0;
    r.vsel     = 4'b0001;
    r.readnum  = ir[2:0];
    r.writenum = ir[10:8];
    r.sximm8   = ir[7] ? {8'hFF, ir[7:0]} : {8'h00, ir[7:0]};
    r.sximm5   = ir[4] ? {11'h7FF, ir[4:0]} : {11'h000, ir[4:0]};
    r.shift    = ir[4:3];
    r.aluop    = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
    return r;
  endfunction

  function automatic outv_t rec_idle(input logic [15:0] ir);
    outv_t r;
    r   = rec_base(ir);
    r.w = 1'b1;
    return r;
  endfunction

  // Expand one instruction into its sequence of per-cycle control records
  task automatic add_steps(input logic [15:0] ir);
    int    ph[$];
    outv_t r;
    logic [2:0] opc;
    logic [1:0] op;
    bit cmp, zero_a;
    opc    = ir[15:13];
    op     = ir[12:11];
    cmp    = (opc == 3'b101) && (op == 2'b01);
    zero_a = ((opc == 3'b110) && (op == 2'b00)) || ((opc == 3'b101) && (op == 2'b11));
    if ((opc == 3'b110) && (op == 2'b10))      ph = '{P_DEC, P_WI};
    else if (zero_a)                           ph = '{P_DEC, P_GB, P_EX, P_WR};
    else if (cmp)                              ph = '{P_DEC, P_GA, P_GB, P_EX};
    else if (opc == 3'b101)                    ph = '{P_DEC, P_GA, P_GB, P_EX, P_WR};
    else                                       ph = '{P_DEC};
    foreach (ph[i]) begin
      r = rec_base(ir);
      case (ph[i])
        P_GA: begin r.loada = 1'b1; r.readnum = ir[10:8]; end
        P_GB: r.loadb = 1'b1;
        P_EX: begin
          r.asel = zero_a;
          if (cmp) r.loads = 1'b1;
          else     r.loadc = 1'b1;
        end
        P_WR: begin r.write = 1'b1; r.writenum = ir[7:5]; end
        P_WI: begin r.write = 1'b1; r.vsel = 4'b0100; end
        default: ;
      endcase
      busy_q.push_back(r);
    end
  endtask

  // Predict outputs for the cycle after the coming edge, given current inputs
  task automatic model_edge();
    outv_t e;
    if (!reset_n) begin
      ir_m   = '0;
      busy_q.delete();
      idle_m = 1'b1;
      e      = rec_idle(ir_m);
    end else if (busy_q.size() > 0) begin
      e = busy_q.pop_front();
    end else if (!idle_m) begin
      idle_m = 1'b1;
      e      = rec_idle(ir_m);
    end else begin
      if (load) ir_m = in;
      if (s) begin
        add_steps(ir_m);
        e      = busy_q.pop_front();
        idle_m = 1'b0;
      end else begin
        e = rec_idle(ir_m);
      end
    end
    exp_q.push_back(e);
    cyc_q.push_back(cyc_n);
    cyc_n++;
  endtask

  task automatic cyc(input logic rst_v, input logic ld, input logic [15:0] word, input logic st);
    reset_n = rst_v;
    load    = ld;
    in      = word;
    s       = st;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0:       r[15:11] = 5'b11010;
      1:       r[15:11] = 5'b11000;
      2, 3:    r[15:13] = 3'b101;
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: compare every cycle's outputs against the predicted record
  outv_t mon_e;
  int    mon_c;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_c = cyc_q.pop_front();
      n_cmp++;
      if (act !== mon_e) begin
        n_bad++;
        $display("FAIL cycle%0d outputs: got %h expected %h (w=%b wr=%b la=%b lb=%b lc=%b ls=%b as=%b vsel=%b rn=%0d wn=%0d)",
                 mon_c, act, mon_e, w, write, loada, loadb, loadc, loads, asel, vsel, readnum, writenum);
      end
    end
  end

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b1);
    idle(2);
    // MOV R2,#-2
    cyc(1'b1, 1'b1, 16'hD2FE, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1);
    idle(3);
    // ADD R5,R1,R0 LSL#1
    cyc(1'b1, 1'b1, 16'hA1A8, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1);
    idle(6);
    // CMP R3,R1 and MVN R7,R2 with load+s together
    cyc(1'b1, 1'b1, 16'hAB01, 1'b1);
    idle(5);
    cyc(1'b1, 1'b1, 16'hB8E2, 1'b1);
    idle(5);
    // load while busy must not disturb IR
    cyc(1'b1, 1'b1, 16'hA1A8, 1'b1);
    cyc(1'b1, 1'b1, 16'hD2FE, 1'b0);
    cyc(1'b1, 1'b1, 16'h1234, 1'b0);
    cyc(1'b1, 1'b1, 16'hFFFF, 1'b0);
    cyc(1'b1, 1'b1, 16'h5555, 1'b0);
    idle(3);
    // Reset held 2 edges while in GET_B of an ADD
    cyc(1'b1, 1'b1, 16'hA1A8, 1'b1);
    idle(2);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    idle(6);
    // Illegal opcode
    cyc(1'b1, 1'b1, 16'h0123, 1'b1);
    idle(3);
    // s held continuously
    cyc(1'b1, 1'b1, 16'hA1A8, 1'b1);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b1);
    idle(7);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
          rand_word(), ($urandom_range(0, 2) == 0));
    end
    idle(4);
    @(negedge clk);
    #1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
